// File: rtl/fir_controller.sv
// Sequencing controller for the FIR datapath: loads one sample into the delay line,
// steps the coefficient address across all taps with MAC enabled, then flags the result.
module fir_controller #(
   parameter int TAPS   = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              FIR_input_valid,
   input  logic              flush_req,
   output logic              shift_en,
   output logic              flush,
   output logic              acc_clear,
   output logic              acc_en,
   output logic [ADDR_W-1:0] coeff_addr,
   output logic              FIR_output_valid,
   output logic              busy,
   output logic              overrun
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_MAC   = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_FLUSH = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

   logic [2:0]        r_state;
   logic [2:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic              r_overrun;
   logic              w_overrun_nxt;

   // flush_req overrides every other transition outside IDLE's own priority order
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      case (r_state)
         S_IDLE: begin
            if (flush_req)            w_state_nxt = S_FLUSH;
            else if (FIR_input_valid) w_state_nxt = S_LOAD;
         end
         S_LOAD:  w_state_nxt = flush_req ? S_FLUSH : S_MAC;
         S_MAC: begin
            if (flush_req) begin
               w_state_nxt = S_FLUSH;
            end else if (r_cnt == LAST_TAP) begin
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt + ADDR_W'(1);
            end
         end
         S_DONE:  w_state_nxt = flush_req ? S_FLUSH : S_IDLE;
         S_FLUSH: w_state_nxt = flush_req ? S_FLUSH : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Entering FLUSH clears the sticky flag even when a late sample would set it
   always_comb begin
      w_overrun_nxt = r_overrun;
      if (w_state_nxt == S_FLUSH)
         w_overrun_nxt = 1'b0;
      else if (FIR_input_valid && (r_state != S_IDLE))
         w_overrun_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_overrun <= w_overrun_nxt;
      end
   end

   assign shift_en         = (r_state == S_LOAD);
   assign flush            = (r_state == S_FLUSH);
   assign acc_clear        = (r_state == S_LOAD) || (r_state == S_FLUSH);
   assign acc_en           = (r_state == S_MAC);
   assign coeff_addr       = (r_state == S_MAC) ? r_cnt : '0;
   assign FIR_output_valid = (r_state == S_DONE);
   assign busy             = (r_state != S_IDLE);
   assign overrun          = r_overrun;

endmodule

// File: tb/tb_fir_controller.sv
// Self-checking bench for fir_controller: a TAPS=2 vector table, directed TAPS=64
// corner sequences and a randomized run against a timeline reference model.
module tb_fir_controller;

   localparam int T  = 64;
   localparam int AW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // TAPS=64 instance
   logic          vi = 1'b0, fr = 1'b0, rs = 1'b1;
   logic          shift_en, flush, acc_clear, acc_en, ovalid, busy, overrun;
   logic [AW-1:0] coeff_addr;

   fir_controller #(.TAPS(T), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rs), .FIR_input_valid(vi), .flush_req(fr),
      .shift_en(shift_en), .flush(flush), .acc_clear(acc_clear), .acc_en(acc_en),
      .coeff_addr(coeff_addr), .FIR_output_valid(ovalid), .busy(busy), .overrun(overrun)
   );

   // TAPS=2 instance
   logic       vi2 = 1'b0, fr2 = 1'b0, rs2 = 1'b1;
   logic       shift_en2, flush2, acc_clear2, acc_en2, ovalid2, busy2, overrun2;
   logic [0:0] coeff_addr2;

   fir_controller #(.TAPS(2), .ADDR_W(1)) dut2 (
      .clk(clk), .rst(rs2), .FIR_input_valid(vi2), .flush_req(fr2),
      .shift_en(shift_en2), .flush(flush2), .acc_clear(acc_clear2), .acc_en(acc_en2),
      .coeff_addr(coeff_addr2), .FIR_output_valid(ovalid2), .busy(busy2), .overrun(overrun2)
   );

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: position within the current sample's timeline.
   // m_off = -1 idle, 0 load, 1..T mac (tap m_off-1), T+1 result valid.
   int m_off  = -1;
   bit m_fl   = 1'b0;
   bit m_ovr  = 1'b0;

   function automatic logic [12:0] model_out();
      logic s, f, c, e, v, b;
      logic [AW-1:0] a;
      s = !m_fl && (m_off == 0);
      f = m_fl;
      c = m_fl || (m_off == 0);
      e = !m_fl && (m_off >= 1) && (m_off <= T);
      v = !m_fl && (m_off == T + 1);
      b = m_fl || (m_off >= 0);
      a = e ? AW'(m_off - 1) : '0;
      return {s, f, c, e, v, b, m_ovr, a};
   endfunction

   task automatic model_update(input bit i_vi, input bit i_fr, input bit i_rs);
      bit was_busy;
      if (i_rs) begin
         m_off = -1; m_fl = 1'b0; m_ovr = 1'b0;
      end else begin
         was_busy = m_fl || (m_off >= 0);
         if (i_fr) begin
            m_fl = 1'b1; m_off = -1; m_ovr = 1'b0;
         end else begin
            if (i_vi && was_busy) m_ovr = 1'b1;
            if (m_fl)              m_fl = 1'b0;
            else if (m_off >= 0)   m_off = (m_off == T + 1) ? -1 : m_off + 1;
            else if (i_vi)         m_off = 0;
         end
      end
   endtask

   function automatic logic [12:0] dut_out();
      return {shift_en, flush, acc_clear, acc_en, ovalid, busy, overrun, coeff_addr};
   endfunction

   task automatic step(input bit i_vi, input bit i_fr, input bit i_rs);
      vi = i_vi; fr = i_fr; rs = i_rs;
      @(posedge clk); #1;
      cyc++;
      model_update(i_vi, i_fr, i_rs);
      chk("model", 32'(dut_out()), 32'(model_out()));
   endtask

   // Table for TAPS=2: exp = {shift, flush, acc_clear, acc_en, addr, valid, busy, overrun}
   typedef struct {
      logic       vi;
      logic       fr;
      logic       rs;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[20];

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'b0000_0000}; // reset
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'b1010_0010}; // LOAD
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'b0001_0010}; // MAC tap 0
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'b0001_1010}; // MAC tap 1
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'b0000_0110}; // DONE, 4 cycles after strobe
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'b0000_0000}; // IDLE
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'b1010_0010}; // LOAD
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'b0001_0011}; // dropped sample sets overrun
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'b0110_0010}; // flush mid-MAC clears overrun
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'b0000_0001}; // sample during FLUSH dropped
      tbl[10] = '{1'b1, 1'b1, 1'b0, 8'b0110_0010}; // flush wins over sample in IDLE
      tbl[11] = '{1'b0, 1'b1, 1'b0, 8'b0110_0010}; // flush held: stay in FLUSH
      tbl[12] = '{1'b0, 1'b0, 1'b0, 8'b0000_0000};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 8'b1010_0010};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 8'b0001_0010};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 8'b0001_1010};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 8'b0000_0110}; // DONE
      tbl[17] = '{1'b0, 1'b1, 1'b0, 8'b0110_0010}; // flush in DONE -> FLUSH
      tbl[18] = '{1'b1, 1'b0, 1'b1, 8'b0000_0000}; // reset beats sample
      tbl[19] = '{1'b0, 1'b0, 1'b0, 8'b0000_0000};

      for (int i = 0; i < 20; i++) begin
         vi2 = tbl[i].vi; fr2 = tbl[i].fr; rs2 = tbl[i].rs;
         @(posedge clk); #1;
         cyc++;
         chk($sformatf("tbl[%0d]", i),
             32'({shift_en2, flush2, acc_clear2, acc_en2, coeff_addr2, ovalid2, busy2, overrun2}),
             32'(tbl[i].exp));
      end
      vi2 = 1'b0; fr2 = 1'b0; rs2 = 1'b1;

      // Reset, then a single sample
      step(0, 0, 1);
      chk("reset_outputs", 32'(dut_out()), 32'd0);
      for (int i = 0; i < 8; i++) step(0, 0, 0);
      step(1, 0, 0);
      chk("load_pulse", 32'({shift_en, acc_clear, acc_en}), 32'b110);
      for (int i = 0; i < T; i++) begin
         step(0, 0, 0);
         chk($sformatf("mac_tap%0d", i), 32'({acc_en, shift_en, coeff_addr}), 32'({2'b10, AW'(i)}));
      end
      step(0, 0, 0);
      chk("result_valid", 32'({ovalid, busy, acc_en}), 32'b110);
      step(0, 0, 0);
      chk("busy_fall", 32'({busy, ovalid}), 32'b00);

      // Sample during MAC is dropped; next strobe in first IDLE cycle is accepted
      step(1, 0, 0);
      for (int i = 0; i < 28; i++) step(0, 0, 0);
      step(1, 0, 0);
      chk("overrun_set", 32'({overrun, acc_en, shift_en}), 32'b110);
      begin
         int n = 0;
         while (busy && n < 100) begin step(0, 0, 0); n++; end
         chk("reach_idle", 32'(busy), 32'd0);
      end
      step(1, 0, 0);
      chk("accept_after_idle", 32'({shift_en, overrun}), 32'b11);

      // Flush at tap 30
      begin
         int n = 0;
         while (!(acc_en && coeff_addr == AW'(30)) && n < 100) begin step(0, 0, 0); n++; end
         chk("reach_tap30", 32'(acc_en && coeff_addr == AW'(30)), 32'd1);
      end
      step(0, 1, 0);
      chk("flush_pulse", 32'({flush, acc_clear, overrun, acc_en, shift_en}), 32'b11000);
      for (int i = 0; i < T + 4; i++) begin
         step(0, 0, 0);
         if (ovalid) chk("no_valid_after_flush", 32'(ovalid), 32'd0);
      end
      chk("idle_after_flush", 32'(busy), 32'd0);

      // Reset mid-MAC at tap 17, with overrun already set
      step(1, 0, 0);
      step(1, 0, 0);
      begin
         int n = 0;
         while (!(acc_en && coeff_addr == AW'(17)) && n < 100) begin step(0, 0, 0); n++; end
         chk("reach_tap17", 32'(acc_en && coeff_addr == AW'(17)), 32'd1);
      end
      chk("overrun_before_rst", 32'(overrun), 32'd1);
      step(0, 0, 1);
      chk("rst_mid_mac", 32'(dut_out()), 32'd0);
      step(0, 0, 0);
      chk("after_rst_idle", 32'(dut_out()), 32'd0);

      // Simultaneous flush and sample in IDLE
      step(1, 1, 0);
      chk("flush_beats_sample", 32'({flush, acc_clear, shift_en, overrun}), 32'b1100);
      step(0, 0, 0);
      chk("idle_after_sim", 32'({busy, shift_en}), 32'b00);

      // Randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0),
              ($urandom_range(0, 499) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
